// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct
// fields, ALU control codes, ALUOp codes and FSM state numbers.
package mips_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct fields (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes driven to the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp: what the FSM asks the ALU decoder for
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_UNUSED = 2'b11;

    // FSM state numbers
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's ALUOp plus the R-type funct
// field into the 3-bit ALU control code.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Map ALUOp/funct to an ALU operation; anything unrecognised adds
    always_comb begin
        // NOTE: default first so every path assigns alu_control and no latch is inferred
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:    alu_control = ALU_ADD;
            ALUOP_SUB:    alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default:      alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control unit of the multicycle MIPS core: a Moore FSM that walks
// each instruction through its states and drives every datapath strobe
// and mux select. ALU operation decode lives in alu_decoder.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(S_FETCH),
        DECODE   = STATE_W'(S_DECODE),
        MEMADR   = STATE_W'(S_MEMADR),
        MEMREAD  = STATE_W'(S_MEMREAD),
        MEMWB    = STATE_W'(S_MEMWB),
        MEMWRITE = STATE_W'(S_MEMWRITE),
        EXECUTE  = STATE_W'(S_EXECUTE),
        ALUWB    = STATE_W'(S_ALUWB),
        BRANCH   = STATE_W'(S_BRANCH),
        ADDIEXEC = STATE_W'(S_ADDIEXEC),
        ADDIWB   = STATE_W'(S_ADDIWB),
        JUMP     = STATE_W'(S_JUMP)
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       done_raw;

    // Next-state selection; only DECODE and MEMADR look at the opcode
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECUTE:  state_next = ALUWB;
            ADDIEXEC: state_next = ADDIWB;
            default:  state_next = FETCH;
        endcase
    end

    // State register; reset drops straight back to FETCH, even mid-instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Moore output decode from state; reset masks the side-effecting strobes
    always_comb begin
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALUOP_ADD;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        done_raw      = 1'b0;
        case (state)
            FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b01;
                pc_write     = 1'b1;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                done_raw  = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
            end
            MEMADR, ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMREAD: iord = 1'b1;
            MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                done_raw      = 1'b1;
            end
            MEMWRITE: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                done_raw      = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                pc_src    = 2'b01;
                done_raw  = 1'b1;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                done_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are held off while reset is high; selects already show FETCH
    assign ir_write   = ir_write_raw  & ~reset;
    assign reg_write  = reg_write_raw & ~reset;
    assign mem_write  = mem_write_raw & ~reset;
    assign instr_done = done_raw      & ~reset;
    assign pc_en      = (pc_write | (branch & zero)) & ~reset;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of instructions,
// each with its expected state walk, feeds an expectation queue that is
// drained one entry per clock; hand-written sequences cover reset.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, instr_done;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          len;
        logic [19:0] seq;   // state walk, one nibble per clock, first in low nibble
    } vec_t;

    vec_t vecs[15];

    multicycle_controller #(.STATE_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .instr_done  (instr_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input logic io, mw, irw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, input logic [2:0] ac,
                                       input logic [1:0] ps, input logic pe, dn);
        return {io, mw, irw, rd, m2r, rw, asa, asb, ac, ps, pe, dn};
    endfunction

    function automatic logic [15:0] actual();
        return {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_control, pc_src, pc_en, instr_done};
    endfunction

    function automatic logic [2:0] funct_code(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs per state, straight from the state/output table
    function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic [5:0] o,
                                             input logic [5:0] f, input logic z);
        logic known;
        known = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
                (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
        case (st)
            4'd0:  return pk(0,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 1, 0);
            4'd1:  return pk(0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0, !known);
            4'd2:  return pk(0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0);
            4'd3:  return pk(1,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0, 0);
            4'd4:  return pk(0,0,0,0,1,1,0, 2'b00, 3'b010, 2'b00, 0, 1);
            4'd5:  return pk(1,1,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0, 1);
            4'd6:  return pk(0,0,0,0,0,0,1, 2'b00, funct_code(f), 2'b00, 0, 0);
            4'd7:  return pk(0,0,0,1,0,1,0, 2'b00, 3'b010, 2'b00, 0, 1);
            4'd8:  return pk(0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, z, 1);
            4'd9:  return pk(0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0);
            4'd10: return pk(0,0,0,0,0,1,0, 2'b00, 3'b010, 2'b00, 0, 1);
            4'd11: return pk(0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b10, 1, 1);
            default: return 16'hxxxx;
        endcase
    endfunction

    // FETCH selects with every strobe forced low
    localparam logic [15:0] RESET_OUTS = 16'b0000000_01_010_00_0_0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b (iord,mw,irw,rd,m2r,rw,asa,asb,ac,ps,pe,done)",
                     name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Pops one expectation and compares it against the live outputs
    task automatic pop_check(input string name, input int cyc);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s cycle %0d: expectation queue empty", name, cyc);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s cycle %0d", name, cyc), actual(), e);
        end
    endtask

    // Drives one instruction from the table and checks every clock of it;
    // entered and left at a falling edge with the FSM expected in FETCH
    task automatic run_vec(input vec_t v);
        logic [19:0] s;
        s = v.seq;
        op    = v.op;
        funct = v.funct;
        zero  = v.zero;
        for (int i = 0; i < v.len; i++)
            exp_q.push_back(exp_outs(s[i*4 +: 4], v.op, v.funct, v.zero));
        for (int i = 0; i < v.len; i++) begin
            #1;
            pop_check(v.name, i);
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{"lw",        6'b100011, 6'b000000, 1'b0, 5, 20'h43210};
        vecs[1]  = '{"add",       6'b000000, 6'b100000, 1'b0, 4, 20'h07610};
        vecs[2]  = '{"sub",       6'b000000, 6'b100010, 1'b1, 4, 20'h07610};
        vecs[3]  = '{"and",       6'b000000, 6'b100100, 1'b0, 4, 20'h07610};
        vecs[4]  = '{"or",        6'b000000, 6'b100101, 1'b0, 4, 20'h07610};
        vecs[5]  = '{"slt",       6'b000000, 6'b101010, 1'b0, 4, 20'h07610};
        vecs[6]  = '{"rtype_bad", 6'b000000, 6'b000111, 1'b0, 4, 20'h07610};
        vecs[7]  = '{"beq_taken", 6'b000100, 6'b000000, 1'b1, 3, 20'h00810};
        vecs[8]  = '{"beq_not",   6'b000100, 6'b000000, 1'b0, 3, 20'h00810};
        vecs[9]  = '{"sw",        6'b101011, 6'b000000, 1'b0, 4, 20'h05210};
        vecs[10] = '{"addi",      6'b001000, 6'b100010, 1'b0, 4, 20'h0a910};
        vecs[11] = '{"j",         6'b000010, 6'b000000, 1'b0, 3, 20'h00b10};
        vecs[12] = '{"nop_op3f",  6'b111111, 6'b000000, 1'b1, 2, 20'h00010};
        vecs[13] = '{"nop_op01",  6'b000001, 6'b100000, 1'b0, 2, 20'h00010};
        vecs[14] = '{"lw_again",  6'b100011, 6'b101010, 1'b1, 5, 20'h43210};

        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b1;

        // Outputs while reset is held from time zero
        #1;
        check("reset_hold", actual(), RESET_OUTS);
        @(negedge clk);
        check("reset_hold_after_edge", actual(), RESET_OUTS);
        reset = 1'b0;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset asserted asynchronously in MEMREAD of a lw
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        exp_q.push_back(exp_outs(4'd0, op, funct, zero));
        exp_q.push_back(exp_outs(4'd1, op, funct, zero));
        exp_q.push_back(exp_outs(4'd2, op, funct, zero));
        exp_q.push_back(exp_outs(4'd3, op, funct, zero));
        for (int i = 0; i < 4; i++) begin
            #1;
            pop_check("lw_pre_reset", i);
            if (i < 3) @(negedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", actual(), RESET_OUTS);
        @(negedge clk);
        check("async_reset_held", actual(), RESET_OUTS);
        reset = 1'b0;
        #1;
        check_bit("post_reset_ir_write", ir_write, 1'b1);
        check_bit("post_reset_pc_en", pc_en, 1'b1);
        check("post_reset_fetch", actual(), exp_outs(4'd0, op, funct, zero));
        @(negedge clk);
        exp_q.push_back(exp_outs(4'd1, op, funct, zero));
        exp_q.push_back(exp_outs(4'd2, op, funct, zero));
        exp_q.push_back(exp_outs(4'd3, op, funct, zero));
        exp_q.push_back(exp_outs(4'd4, op, funct, zero));
        for (int i = 1; i < 5; i++) begin
            #1;
            pop_check("lw_post_reset", i);
            @(negedge clk);
        end

        // Back in FETCH after the restarted lw
        #1;
        check("final_fetch", actual(), exp_outs(4'd0, op, funct, zero));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit of the multicycle MIPS core. It is the initiator for the register file write port (reg_write, reg_dst, mem_to_reg), for the memory port, and for all datapath mux selects and enables. It sequences each instruction through a Moore FSM and decodes ALU operations in a small combinational sub-block.

Parameters:
STATE_W, 4, width of the state register (12 states encoded 0..11)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load enable
reg_dst  output  1  register file A3 select: 0=rt, 1=rd
mem_to_reg  output  1  register file WD3 select: 0=ALUOut, 1=Data
reg_write  output  1  register file WE3
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  output  2  00=ALUResult, 01=ALUOut, 10=jump target
pc_en  output  1  PC load = pc_write | (branch & zero)
instr_done  output  1  one-cycle pulse in the final state of every instruction

Behaviour:
- States: FETCH(0) DECODE(1) MEMADR(2) MEMREAD(3) MEMWB(4) MEMWRITE(5) EXECUTE(6) ALUWB(7) BRANCH(8) ADDIEXEC(9) ADDIWB(10) JUMP(11).
- Transitions:
  - FETCH always goes to DECODE.
  - DECODE on op: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEXEC; j 000010 -> JUMP; any other op -> FETCH, treated as a NOP, with instr_done=1 in DECODE.
  - MEMADR goes to MEMREAD if op=lw, otherwise to MEMWRITE.
  - MEMREAD -> MEMWB; EXECUTE -> ALUWB; ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP all go to FETCH.
- Outputs are Moore, decoded from state only, except pc_en, which uses zero combinationally. Any signal not listed for a state is 0.
  - FETCH: ir_write=1, alu_src_b=01, ALUOp=00, pc_write=1, pc_src=00.
  - DECODE: alu_src_b=11, ALUOp=00.
  - MEMADR and ADDIEXEC: alu_src_a=1, alu_src_b=10, ALUOp=00.
  - MEMREAD: iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWRITE: iord=1, mem_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, ALUOp=10.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=01, branch=1, pc_src=01.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - JUMP: pc_write=1, pc_src=10.
- instr_done is 1 in MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP, and in DECODE for an unknown op.
- Latency in clocks: lw 5; sw, R-type and addi 4; beq and j 3; unknown op 2.
- ALU decode:
  - ALUOp 00 -> 010; ALUOp 01 -> 110; ALUOp 11 (unused) -> 010.
  - ALUOp 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
- Reset:
  - Asserting reset forces the state to FETCH immediately, including mid-instruction.
  - While reset is high, ir_write, pc_en, reg_write, mem_write and instr_done are forced to 0. Mux selects show FETCH values: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, alu_control=010.
  - On the first rising edge after reset deasserts, FETCH strobes are live, so the first fetch completes in that cycle.
- Registers are written on rising edges only. The register file itself is not read or written by this block.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants and ALU_* 3-bit control codes;
  - state localparams S_FETCH..S_JUMP;
  - ALUOp codes.
- Sub-module alu_decoder (inputs alu_op[1:0] and funct[5:0], output alu_control[2:0]) is purely combinational. The FSM and the output decode stay in multicycle_controller.

Test Plan:
- lw (op=100011): states 0,1,2,3,4 over 5 clocks. In MEMREAD iord=1. In MEMWB reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. reg_write is 0 in every other cycle.
- R-type add then sub (op=0, funct=100000 then 100010): alu_control=010 and then 110 in EXECUTE. In ALUWB reg_write=1, reg_dst=1. Each instruction takes 4 clocks.
- beq (op=000100): in BRANCH with zero=1, pc_en=1 and pc_src=01. Repeat with zero=0: pc_en=0 in BRANCH. Both take 3 clocks.
- sw, addi and j:
  - sw: mem_write=1 only in MEMWRITE, with iord=1.
  - addi: ADDIWB has reg_write=1, reg_dst=0.
  - j: JUMP has pc_en=1, pc_src=10.
- Unknown op=111111: FETCH, then DECODE with instr_done=1, then FETCH. No reg_write or mem_write at any point.
- Reset asserted asynchronously during MEMREAD of a lw: state returns to FETCH at once and all strobes are 0 while reset is held. After release, ir_write=1 and pc_en=1 on the first cycle.
